// File: rtl/eth_bus_arbiter.sv
// Three-client bus arbiter for the Ethernet bus engine.
// Client 0 has fixed priority; clients 1 and 2 share round-robin.
module eth_bus_arbiter #(
  parameter logic [15:0] TIMEOUT    = 16'd50000,
  parameter logic [3:0]  WAIT_STATE = 4'b1001
) (
  input  logic        clk40m,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  rel,
  input  logic [23:0] c_offset,
  input  logic [2:0]  c_length,
  input  logic [2:0]  c_WR,
  input  logic [47:0] c_writeData,
  input  logic [2:0]  c_NewCommand,
  input  logic [2:0]  c_Dummy_Read,
  input  logic [3:0]  state,
  input  logic        err_clr,
  output logic [7:0]  offset,
  output logic        length,
  output logic        WR,
  output logic [15:0] writeData,
  output logic        NewCommand,
  output logic        Dummy_Read,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_DRAIN
  } st_t;

  st_t         r_st, w_st_nxt;
  logic        r_arm;
  logic        r_ptr2, w_ptr2_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_err, w_err_nxt;
  logic [2:0]  r_grant, w_grant_nxt;
  logic [7:0]  r_off, w_off_nxt;
  logic        r_len, w_len_nxt;
  logic        r_wr, w_wr_nxt;
  logic [15:0] r_wd, w_wd_nxt;
  logic        r_nc, w_nc_nxt;
  logic        r_dr, w_dr_nxt;

  logic        w_bus_idle;
  logic        w_rel;
  logic        w_tmo;
  logic [2:0]  w_win;
  logic [7:0]  w_s_off;
  logic        w_s_len;
  logic        w_s_wr;
  logic [15:0] w_s_wd;
  logic        w_s_nc;
  logic        w_s_dr;

  assign w_bus_idle = (state == WAIT_STATE);
  assign w_rel      = |(rel & r_grant);
  assign w_tmo      = (r_cnt == TIMEOUT - 16'd1);

  always_comb begin
    w_s_off = '0;
    w_s_len = 1'b0;
    w_s_wr  = 1'b0;
    w_s_wd  = '0;
    w_s_nc  = 1'b0;
    w_s_dr  = 1'b0;
    unique case (1'b1)
      r_grant[0]: begin
        w_s_off = c_offset[7:0];
        w_s_len = c_length[0];
        w_s_wr  = c_WR[0];
        w_s_wd  = c_writeData[15:0];
        w_s_nc  = c_NewCommand[0];
        w_s_dr  = c_Dummy_Read[0];
      end
      r_grant[1]: begin
        w_s_off = c_offset[15:8];
        w_s_len = c_length[1];
        w_s_wr  = c_WR[1];
        w_s_wd  = c_writeData[31:16];
        w_s_nc  = c_NewCommand[1];
        w_s_dr  = c_Dummy_Read[1];
      end
      r_grant[2]: begin
        w_s_off = c_offset[23:16];
        w_s_len = c_length[2];
        w_s_wr  = c_WR[2];
        w_s_wd  = c_writeData[47:32];
        w_s_nc  = c_NewCommand[2];
        w_s_dr  = c_Dummy_Read[2];
      end
      default: ;
    endcase
  end

  // r_ptr2 set means client 2 was served last, so client 1 wins a tie
  always_comb begin
    w_win = 3'b000;
    if (req[0])
      w_win = 3'b001;
    else if (req[1] && req[2])
      w_win = r_ptr2 ? 3'b010 : 3'b100;
    else if (req[1])
      w_win = 3'b010;
    else if (req[2])
      w_win = 3'b100;
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_ptr2_nxt  = r_ptr2;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = err_clr ? 1'b0 : r_err;
    w_grant_nxt = r_grant;
    w_off_nxt   = r_off;
    w_len_nxt   = r_len;
    w_wr_nxt    = r_wr;
    w_wd_nxt    = r_wd;
    w_nc_nxt    = 1'b0;
    w_dr_nxt    = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        w_off_nxt = '0;
        w_len_nxt = 1'b0;
        w_wr_nxt  = 1'b0;
        w_wd_nxt  = '0;
        if (r_arm && |req && w_bus_idle) begin
          w_st_nxt    = S_GRANT;
          w_grant_nxt = w_win;
          w_cnt_nxt   = '0;
          if (w_win[1]) w_ptr2_nxt = 1'b0;
          if (w_win[2]) w_ptr2_nxt = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_rel) begin
          w_st_nxt    = S_DRAIN;
          w_grant_nxt = '0;
        end else if (w_tmo) begin
          w_st_nxt    = S_DRAIN;
          w_grant_nxt = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_off_nxt = w_s_off;
          w_len_nxt = w_s_len;
          w_wr_nxt  = w_s_wr;
          w_wd_nxt  = w_s_wd;
          w_nc_nxt  = w_s_nc;
          w_dr_nxt  = w_s_dr;
          if (r_cnt != 16'hFFFF)
            w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_DRAIN: begin
        if (w_bus_idle) begin
          w_st_nxt  = S_IDLE;
          w_off_nxt = '0;
          w_len_nxt = 1'b0;
          w_wr_nxt  = 1'b0;
          w_wd_nxt  = '0;
        end
      end
      default: w_st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) r_st <= S_IDLE;
    else        r_st <= w_st_nxt;
  end

  // r_arm holds off arbitration for the first edge after reset
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      r_arm   <= 1'b0;
      r_ptr2  <= 1'b1;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_grant <= '0;
      r_off   <= '0;
      r_len   <= 1'b0;
      r_wr    <= 1'b0;
      r_wd    <= '0;
      r_nc    <= 1'b0;
      r_dr    <= 1'b0;
    end else begin
      r_arm   <= 1'b1;
      r_ptr2  <= w_ptr2_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_grant <= w_grant_nxt;
      r_off   <= w_off_nxt;
      r_len   <= w_len_nxt;
      r_wr    <= w_wr_nxt;
      r_wd    <= w_wd_nxt;
      r_nc    <= w_nc_nxt;
      r_dr    <= w_dr_nxt;
    end
  end

  assign offset      = r_off;
  assign length      = r_len;
  assign WR          = r_wr;
  assign writeData   = r_wd;
  assign NewCommand  = r_nc;
  assign Dummy_Read  = r_dr;
  assign grant       = r_grant;
  assign busy        = (r_st != S_IDLE);
  assign timeout_err = r_err;

endmodule

// File: tb/tb_eth_bus_arbiter.sv
// Directed bench for eth_bus_arbiter with hand-computed expectations.
// TIMEOUT is shortened to 16 so the hold limit is reachable quickly.
module tb_eth_bus_arbiter;

  logic        clk40m = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  rel;
  logic [23:0] c_offset;
  logic [2:0]  c_length;
  logic [2:0]  c_WR;
  logic [47:0] c_writeData;
  logic [2:0]  c_NewCommand;
  logic [2:0]  c_Dummy_Read;
  logic [3:0]  state;
  logic        err_clr;
  logic [7:0]  offset;
  logic        length;
  logic        WR;
  logic [15:0] writeData;
  logic        NewCommand;
  logic        Dummy_Read;
  logic [2:0]  grant;
  logic        busy;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  eth_bus_arbiter #(
    .TIMEOUT(16'd16),
    .WAIT_STATE(4'b1001)
  ) dut (
    .clk40m(clk40m),
    .reset(reset),
    .req(req),
    .rel(rel),
    .c_offset(c_offset),
    .c_length(c_length),
    .c_WR(c_WR),
    .c_writeData(c_writeData),
    .c_NewCommand(c_NewCommand),
    .c_Dummy_Read(c_Dummy_Read),
    .state(state),
    .err_clr(err_clr),
    .offset(offset),
    .length(length),
    .WR(WR),
    .writeData(writeData),
    .NewCommand(NewCommand),
    .Dummy_Read(Dummy_Read),
    .grant(grant),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #12 clk40m = ~clk40m;

  task automatic step();
    @(posedge clk40m);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0; rel = '0; err_clr = 1'b0;
    state = 4'd9;
    c_offset = '0; c_length = '0; c_WR = '0;
    c_writeData = '0; c_NewCommand = '0;
    c_Dummy_Read = '0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic pulse_rel(input logic [2:0] r);
    rel = r;
    step();
    rel = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 3'b001; rel = '0; err_clr = 1'b0;
    state = 4'd9;
    c_offset = '0; c_length = '0; c_WR = '0;
    c_writeData = '0; c_NewCommand = '0;
    c_Dummy_Read = '0;
    step();
    checks++;
    if ({grant, busy, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs grant=%b busy=%b err=%b exp 000/0/0",
               grant, busy, timeout_err);
    end
    checks++;
    if ({offset, WR, writeData, NewCommand} !== 26'b0) begin
      errors++;
      $display("FAIL reset_cmd off=%h wd=%h nc=%b exp 0",
               offset, writeData, NewCommand);
    end
    reset = 1'b1;
    step();
    checks++;
    if (grant !== 3'b000) begin
      errors++;
      $display("FAIL reset_first_edge grant=%b exp=000", grant);
    end
    step();
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL reset_second_edge grant=%b exp=001", grant);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 3'b110;
    step();
    checks++;
    if (grant !== 3'b010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rr_first grant=%b busy=%b exp 010/1", grant, busy);
    end
    pulse_rel(3'b010);
    checks++;
    if (grant !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rr_drain grant=%b busy=%b exp 000/1", grant, busy);
    end
    step();
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle grant=%b busy=%b exp 000/0", grant, busy);
    end
    step();
    checks++;
    if (grant !== 3'b100) begin
      errors++;
      $display("FAIL rr_second grant=%b exp=100", grant);
    end
    pulse_rel(3'b001);
    checks++;
    if (grant !== 3'b100) begin
      errors++;
      $display("FAIL rr_foreign_rel grant=%b exp=100", grant);
    end
    pulse_rel(3'b100);
    step();
    step();
    checks++;
    if (grant !== 3'b010) begin
      errors++;
      $display("FAIL rr_third grant=%b exp=010", grant);
    end
  endtask

  task automatic test_priority();
    do_reset();
    req = 3'b111;
    step();
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL prio_first grant=%b exp=001", grant);
    end
    pulse_rel(3'b001);
    step();
    step();
    checks++;
    if (grant !== 3'b001) begin
      errors++;
      $display("FAIL prio_again grant=%b exp=001", grant);
    end
    req = 3'b110;
    pulse_rel(3'b001);
    step();
    step();
    checks++;
    if (grant !== 3'b010) begin
      errors++;
      $display("FAIL prio_c1 grant=%b exp=010", grant);
    end
    pulse_rel(3'b010);
    step();
    step();
    checks++;
    if (grant !== 3'b100) begin
      errors++;
      $display("FAIL prio_c2 grant=%b exp=100", grant);
    end
  endtask

  task automatic test_datapath();
    do_reset();
    c_offset = 24'h90_22_11;
    c_writeData = 48'hEB00_2222_1111;
    c_WR = 3'b100;
    c_length = 3'b100;
    c_NewCommand = 3'b100;
    req = 3'b100;
    step();
    checks++;
    if (grant !== 3'b100 || offset !== 8'h00) begin
      errors++;
      $display("FAIL dp_grant grant=%b off=%h exp 100/00", grant, offset);
    end
    step();
    checks++;
    if (offset !== 8'h90 || writeData !== 16'hEB00 ||
        WR !== 1'b1 || NewCommand !== 1'b1 || length !== 1'b1) begin
      errors++;
      $display("FAIL dp_latch off=%h wd=%h wr=%b nc=%b len=%b exp 90/EB00/1/1/1",
               offset, writeData, WR, NewCommand, length);
    end
    req = 3'b000;
    step();
    checks++;
    if (grant !== 3'b100) begin
      errors++;
      $display("FAIL dp_req_drop grant=%b exp=100", grant);
    end
    state = 4'b0100;
    pulse_rel(3'b100);
    checks++;
    if (NewCommand !== 1'b0 || busy !== 1'b1 || offset !== 8'h90) begin
      errors++;
      $display("FAIL drain_out nc=%b busy=%b off=%h exp 0/1/90",
               NewCommand, busy, offset);
    end
    step();
    checks++;
    if (busy !== 1'b1 || grant !== 3'b000) begin
      errors++;
      $display("FAIL drain_hold busy=%b grant=%b exp 1/000", busy, grant);
    end
    state = 4'd9;
    req = 3'b100;
    step();
    checks++;
    if (busy !== 1'b0 || grant !== 3'b000 || offset !== 8'h00) begin
      errors++;
      $display("FAIL drain_exit busy=%b grant=%b off=%h exp 0/000/00",
               busy, grant, offset);
    end
    step();
    checks++;
    if (grant !== 3'b100) begin
      errors++;
      $display("FAIL drain_regrant grant=%b exp=100", grant);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 3'b010;
    step();
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (grant !== 3'b010 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_before grant=%b err=%b exp 010/0", grant, timeout_err);
    end
    step();
    checks++;
    if (grant !== 3'b000 || timeout_err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_hit grant=%b err=%b busy=%b exp 000/1/1",
               grant, timeout_err, busy);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear err=%b exp=0", timeout_err);
    end
    step();
    for (int i = 0; i < 15; i++) step();
    pulse_rel(3'b010);
    checks++;
    if (grant !== 3'b000 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_rel_wins grant=%b err=%b exp 000/0", grant, timeout_err);
    end
    step();
    step();
    for (int i = 0; i < 15; i++) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_set_wins err=%b exp=1", timeout_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    c_NewCommand = 3'b001;
    c_offset = 24'h00_00_5A;
    req = 3'b001;
    step();
    step();
    checks++;
    if (grant !== 3'b001 || NewCommand !== 1'b1) begin
      errors++;
      $display("FAIL ares_pre grant=%b nc=%b exp 001/1", grant, NewCommand);
    end
    #4;
    reset = 1'b0;
    #1;
    checks++;
    if (grant !== 3'b000 || NewCommand !== 1'b0 ||
        busy !== 1'b0 || offset !== 8'h00) begin
      errors++;
      $display("FAIL ares_mid grant=%b nc=%b busy=%b off=%h exp 000/0/0/00",
               grant, NewCommand, busy, offset);
    end
    step();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_priority();
    test_datapath();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_bus_arbiter.md
ETH_BUS_ARBITER -- requirements
Module: eth_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000: maximum cycles one client may hold the grant.
REQ-002 SHALL have parameter WAIT_STATE, default 4'b1001: bus-engine idle state code.
REQ-003 SHALL have port clk40m  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  3  per-client request; client 0 = init, 1 = receive, 2 = transmit.
REQ-006 SHALL have port rel  input  3  per-client one-cycle release pulse.
REQ-007 SHALL have port c_offset  input  24  client offsets, client i in bits [8i+7:8i].
REQ-008 SHALL have port c_length  input  3  client length bits.
REQ-009 SHALL have port c_WR  input  3  client write strobes.
REQ-010 SHALL have port c_writeData  input  48  client write data, client i in bits [16i+15:16i].
REQ-011 SHALL have port c_NewCommand  input  3  client command-valid bits.
REQ-012 SHALL have port c_Dummy_Read  input  3  client dummy-read bits.
REQ-013 SHALL have port state  input  4  bus-engine state code.
REQ-014 SHALL have port err_clr  input  1  clears timeout_err.
REQ-015 SHALL have ports offset (8), length (1), WR (1), writeData (16), NewCommand (1), Dummy_Read (1)  output  registered drive to the bus engine.
REQ-016 SHALL have port grant  output  3  one-hot grant, all zero when no client is granted.
REQ-017 SHALL have port busy  output  1  high in GRANT or DRAIN.
REQ-018 SHALL have port timeout_err  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, GRANT, DRAIN.
REQ-020 IDLE: SHALL grant only when |req is high and state == WAIT_STATE; otherwise SHALL remain in IDLE.
REQ-021 Arbitration SHALL give client 0 fixed top priority; clients 1 and 2 SHALL round-robin via a last-served pointer, reset value 2, so client 1 wins the first tie.
REQ-022 On grant, grant SHALL go one-hot on the next edge, the pointer SHALL update if client 1 or 2 won, the hold counter SHALL load 0, and the FSM SHALL enter GRANT.
REQ-023 GRANT: command outputs SHALL register the granted client's inputs each cycle, giving one cycle of latency from client input to output.
REQ-024 GRANT: the hold counter SHALL increment by 1 per cycle and SHALL saturate at 16'hFFFF.
REQ-025 GRANT: rel of the granted client SHALL move the FSM to DRAIN; rel bits of non-granted clients SHALL be ignored.
REQ-026 GRANT: when the counter equals TIMEOUT-1 and no rel is present, the FSM SHALL enter DRAIN and timeout_err SHALL set.
REQ-027 If rel and timeout occur in the same cycle, rel SHALL win and timeout_err SHALL stay unchanged.
REQ-028 DRAIN: grant SHALL clear; NewCommand and Dummy_Read SHALL be 0; offset, length, WR and writeData SHALL hold their last values.
REQ-029 DRAIN: the FSM SHALL return to IDLE when state == WAIT_STATE; no new grant SHALL be issued in that same cycle, giving a minimum of one IDLE cycle between grants.
REQ-030 IDLE: all command outputs SHALL be 0.
REQ-031 Deasserting req while granted SHALL NOT end the grant; only rel or timeout SHALL end it.
REQ-032 timeout_err SHALL clear on err_clr; if a timeout and err_clr coincide, set SHALL win.

Reset
REQ-033 Asserting reset low SHALL immediately force IDLE, grant = 0, busy = 0, timeout_err = 0, all command outputs to 0, hold counter to 0, and pointer to 2, including in the middle of a grant.
REQ-034 After reset deasserts, the first grant SHALL be no earlier than the second rising edge.

Verification
REQ-035 Bench SHALL cover: req = 3'b110, state = 9 -> grant = 3'b010; after client 1 rel and drain, grant = 3'b100 (round-robin).
REQ-036 Bench SHALL cover: req = 3'b111 continuously -> client 0 granted every arbitration; clients 1 and 2 alternate only when req[0] = 0.
REQ-037 Bench SHALL cover: client 2 granted with c_offset[23:16] = 8'h90, c_writeData[47:32] = 16'hEB00, c_WR[2] = 1 -> one cycle later offset = 8'h90, writeData = 16'hEB00, WR = 1.
REQ-038 Bench SHALL cover: TIMEOUT = 16, grant held with no rel -> DRAIN after 16 grant cycles, timeout_err = 1; err_clr pulse -> timeout_err = 0.
REQ-039 Bench SHALL cover: rel pulse while state = 4'b0100 -> NewCommand = 0 immediately, busy stays 1 until state = 9, then one IDLE cycle before the next grant.
REQ-040 Bench SHALL cover: reset pulsed low mid-GRANT -> grant = 0 and NewCommand = 0 asynchronously, before the next clock edge.
